fetch_unit: RTL

//  Instruction-fetch stage directly upstream of the control decoder. It owns the PC and the instruction

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_unit_pc_next.sv | 25 ++
 rtl/fetch_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and the pc_src encoding driven by control.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        DATA  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b11;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_HOLD   = 2'b00;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: sequential increment, jump, branch or hold.
module pc_next
    import cpu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int PC_INC = 4
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] next_pc
);

    always_comb begin
        next_pc = pc;
        case (pc_src)
            PC_SRC_SEQ:    next_pc = pc + WIDTH'(PC_INC);
            PC_SRC_JUMP:   next_pc = jump_target;
            PC_SRC_BRANCH: next_pc = branch_target;
            default:       next_pc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, sequences FETCH/EXEC/DATA over one ready-handshaked
// memory port and halts with a sticky fault when memory stops answering.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               PC_INC     = 4,
    parameter int               WAIT_LIMIT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             ir_write,
    input  logic             iord,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] data_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_req,
    output logic [WIDTH-1:0] ins,
    output logic             ins_valid,
    output logic [WIDTH-1:0] pc,
    output logic             fault
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    fetch_state_t     state_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] ir_reg;
    logic [CW-1:0]    wait_reg;
    logic             fault_reg;
    logic             ir_load_reg;
    logic [1:0]       src_sel;
    logic [WIDTH-1:0] next_pc;
    logic             wait_expired;

    // Completing a data access always advances sequentially, whatever control drives.
    assign src_sel      = (state_reg == DATA) ? PC_SRC_SEQ : pc_src;
    assign wait_expired = (wait_reg == CW'(WAIT_LIMIT - 1));

    pc_next #(
        .WIDTH  (WIDTH),
        .PC_INC (PC_INC)
    ) u_pc_next (
        .pc            (pc_reg),
        .pc_src        (src_sel),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            wait_reg    <= '0;
            fault_reg   <= 1'b0;
            ir_load_reg <= 1'b1;
        end else begin
            case (state_reg)
                FETCH, DATA: begin
                    if (mem_ready) begin
                        wait_reg <= '0;
                        if (state_reg == FETCH) begin
                            if (ir_load_reg) begin
                                ir_reg <= mem_rdata;
                            end
                            state_reg <= EXEC;
                        end else begin
                            pc_reg    <= next_pc;
                            state_reg <= FETCH;
                        end
                    end else if (wait_expired) begin
                        wait_reg  <= '0;
                        fault_reg <= 1'b1;
                        state_reg <= HALT;
                    end else begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end
                EXEC: begin
                    // The last EXEC cycle's ir_write governs the next instruction fetch.
                    ir_load_reg <= ir_write;
                    if (iord) begin
                        state_reg <= DATA;
                    end else if (pc_write) begin
                        pc_reg    <= next_pc;
                        state_reg <= FETCH;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Gating with reset abandons an in-flight access during the reset cycle itself.
    assign mem_req   = ((state_reg == FETCH) || (state_reg == DATA)) && !reset;
    assign mem_addr  = (state_reg == DATA) ? data_addr : pc_reg;
    assign ins       = ir_reg;
    assign ins_valid = (state_reg == EXEC);
    assign pc        = pc_reg;
    assign fault     = fault_reg;

endmodule
